// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot program loader.
// The state set depends on LOADER_CHECKSUM_EN (CHECK state exists only when defined).
package loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int BYTE_W     = 8;
    localparam int CNT_W      = 2 * BYTE_W;   // word count arrives as two bytes

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CNT_HI  = 4'd1,
        CNT_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHECK   = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_e;
`else
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CNT_HI  = 4'd1,
        CNT_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_e;
`endif

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a big-endian word count followed by
// that many words (high byte first) and writes them to consecutive memory
// addresses from 0, holding the CPU halted until the load completes.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// CNT_HI  | waiting for word-count high byte
// CNT_LO  | waiting for word-count low byte; range-check count
// DATA_HI | waiting for data word high byte
// DATA_LO | waiting for data word low byte
// WRITE   | one-cycle memory write strobe
// CHECK   | waiting for checksum byte (checksum build only)
// DONE    | load complete, CPU released
// ERR     | load aborted
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_save,
    output logic              cpu_halt,
    output logic              done,
    output logic              error
);

    // Largest loadable count: one word per address.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W:0]      wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   mem_in_q, mem_in_d;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   xor_q, xor_d;
`endif

    logic              xfer;
    logic [CNT_W-1:0]  cnt_full;
    state_e            finish_state;

    assign xfer     = rx_valid && rx_ready;
    assign cnt_full = {cnt_q[CNT_W-1:BYTE_W], rx_data};

`ifdef LOADER_CHECKSUM_EN
    assign finish_state = CHECK;
`else
    assign finish_state = DONE;
`endif

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_cnt_q <= '0;
            addr_q   <= '0;
            hi_q     <= '0;
            mem_in_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_cnt_q <= wr_cnt_d;
            addr_q   <= addr_d;
            hi_q     <= hi_d;
            mem_in_q <= mem_in_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    // Next-state and datapath updates; outputs decode directly from state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_cnt_d = wr_cnt_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        mem_in_d = mem_in_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d    = xor_q;
`endif

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    cnt_d    = '0;
                    wr_cnt_d = '0;
                    addr_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d    = '0;
`endif
                    state_d  = CNT_HI;
                end
            end
            CNT_HI: begin
                if (xfer) begin
                    cnt_d   = {rx_data, cnt_q[BYTE_W-1:0]};
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (xfer) begin
                    cnt_d = cnt_full;
                    if (cnt_full == '0)
                        state_d = finish_state;
                    else if (32'(cnt_full) > MAX_WORDS)
                        state_d = ERR;
                    else
                        state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ rx_data;
`endif
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    mem_in_d = DATA_W'({hi_q, rx_data});
`ifdef LOADER_CHECKSUM_EN
                    xor_d    = xor_q ^ rx_data;
`endif
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                // Address only advances when more words follow, so a full
                // 2**ADDR_W load ends on the top address instead of wrapping.
                if (wr_cnt_d == {1'b0, cnt_q}) begin
                    state_d = finish_state;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer)
                    state_d = (rx_data == xor_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output decode from current state.
    always_comb begin
        rx_ready = 1'b0;
        unique case (state_q)
            CNT_HI, CNT_LO, DATA_HI, DATA_LO: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:                            rx_ready = 1'b1;
`endif
            default:                          rx_ready = 1'b0;
        endcase
        mem_save = (state_q == WRITE);
        cpu_halt = (state_q != DONE);
        done     = (state_q == DONE);
        error    = (state_q == ERR);
        mem_addr = addr_q;
        mem_in   = mem_in_q;
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as the
// stream is issued; a monitor pops and compares on every mem_save.
`timescale 1ns/1ps
module tb_program_loader;
    import loader_pkg::*;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic          mem_save;
    logic          cpu_halt;
    logic          done;
    logic          error;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    logic [15:0] wq[$];

    int total = 0;
    int bad   = 0;

    program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_save (mem_save),
        .cpu_halt (cpu_halt),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_save === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h want no write", mem_addr, mem_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", int'(mem_addr), e.addr);
                chk("write_data", int'(mem_in), e.data);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'hEE;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Issue a full load of wq[0..cnt-1]; queue the expected writes first.
    task automatic load(input int cnt, input bit gap, input logic [7:0] cs_flip);
        logic [7:0]  x;
        logic [15:0] w;
        logic [15:0] c;
        x = 8'h00;
        c = 16'(cnt);
        start_pulse();
        send_byte(c[15:8], gap);
        send_byte(c[7:0], gap);
        if (cnt <= (1 << AW)) begin
            for (int i = 0; i < cnt; i++) begin
                w = wq[i];
                exp_q.push_back('{addr: i, data: int'(w)});
                x = x ^ w[15:8] ^ w[7:0];
                send_byte(w[15:8], gap);
                send_byte(w[7:0], gap);
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(x ^ cs_flip, gap);
`endif
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("end_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", int'(rx_ready), 0);
        chk("rst_mem_save", int'(mem_save), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_in",   int'(mem_in),   0);
        chk("rst_done",     int'(done),     0);
        chk("rst_error",    int'(error),    0);
        chk("rst_cpu_halt", int'(cpu_halt), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-word load.
        wq = '{16'h1234, 16'hABCD};
        load(2, 1'b0, 8'h00);
        wait_end();
        chk("t1_done",     int'(done),     1);
        chk("t1_error",    int'(error),    0);
        chk("t1_cpu_halt", int'(cpu_halt), 0);
        chk("t1_addr_hold", int'(mem_addr), 1);
        chk("t1_data_hold", int'(mem_in),  16'hABCD);
        chk("t1_rx_ready", int'(rx_ready), 0);
        chk("t1_pending",  exp_q.size(),   0);

        // Zero count: completes straight after the count bytes.
        load(0, 1'b0, 8'h00);
        @(negedge clk);
        chk("t2_done",     int'(done),     1);
        chk("t2_cpu_halt", int'(cpu_halt), 0);
        chk("t2_addr",     int'(mem_addr), 0);

        // Oversize count is rejected; a new start clears error.
        load(1025, 1'b0, 8'h00);
        wait_end();
        chk("t3_error",    int'(error),    1);
        chk("t3_done",     int'(done),     0);
        chk("t3_cpu_halt", int'(cpu_halt), 1);
        start_pulse();
        chk("t3_err_clr",  int'(error),    0);
        chk("t3_rx_ready", int'(rx_ready), 1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        wait_end();
        chk("t3_done_after", int'(done), 1);

        // Same two-word stream with rx_valid gapped every other cycle.
        wq = '{16'h1234, 16'hABCD};
        load(2, 1'b1, 8'h00);
        wait_end();
        chk("t4_done",    int'(done),   1);
        chk("t4_pending", exp_q.size(), 0);

        // Full-depth load: last write at top address, no wrap.
        wq.delete();
        for (int i = 0; i < (1 << AW); i++) wq.push_back(16'(i * 37 + 16'h0A05));
        load(1 << AW, 1'b0, 8'h00);
        wait_end();
        chk("t5_done",     int'(done),     1);
        chk("t5_last_addr", int'(mem_addr), (1 << AW) - 1);
        chk("t5_pending",  exp_q.size(),   0);

        // Reset after first data byte abandons the load.
        start_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rx_ready", int'(rx_ready), 0);
        chk("t6_mem_save", int'(mem_save), 0);
        chk("t6_mem_addr", int'(mem_addr), 0);
        chk("t6_mem_in",   int'(mem_in),   0);
        chk("t6_done",     int'(done),     0);
        chk("t6_error",    int'(error),    0);
        chk("t6_cpu_halt", int'(cpu_halt), 1);
        @(negedge clk);
        rst_n    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h34;
        repeat (10) @(negedge clk);
        rx_valid = 1'b0;
        chk("t6_idle_ready", int'(rx_ready), 0);
        chk("t6_idle_halt",  int'(cpu_halt), 1);
        chk("t6_idle_done",  int'(done),     0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good (12^34 = 26) then bad (27).
        wq = '{16'h1234};
        load(1, 1'b0, 8'h00);
        wait_end();
        chk("t7_done",  int'(done),  1);
        chk("t7_error", int'(error), 0);
        load(1, 1'b0, 8'h01);
        wait_end();
        chk("t7b_error",   int'(error),  1);
        chk("t7b_done",    int'(done),   0);
        chk("t7b_pending", exp_q.size(), 0);
`endif

        repeat (3) @(negedge clk);
        chk("final_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the memory word-address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the memory word width; the byte stream SHALL fill it as two bytes.
REQ-003 clk  input  1  single clock, rising edge; all state SHALL be clocked by it.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 rx_data  input  8  incoming stream byte.
REQ-007 rx_valid  input  1  rx_data is valid.
REQ-008 rx_ready  output  1  loader accepts a byte; a byte transfers on a cycle with rx_valid and rx_ready both high.
REQ-009 mem_addr  output  ADDR_W  word address to the memory data port.
REQ-010 mem_in  output  DATA_W  word to the memory data port.
REQ-011 mem_save  output  1  write strobe to the memory data port, one cycle per word.
REQ-012 cpu_halt  output  1  holds the processor stopped while memory is not validly loaded.
REQ-013 done  output  1  sticky; load completed successfully.
REQ-014 error  output  1  sticky; load aborted.

Function
REQ-015 States SHALL be IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE and ERR.
REQ-016 From IDLE, DONE or ERR, start SHALL clear done and error, zero the word counter and address, and go to CNT_HI; start in any other state SHALL be ignored.
REQ-017 rx_ready SHALL be high only in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHECK.
REQ-018 Stream format: 2-byte word count, big-endian, then count words, each high byte first.
REQ-019 Count 0 SHALL go directly to DONE, or to CHECK when the checksum feature is enabled, with no writes.
REQ-020 Count greater than 2**ADDR_W SHALL go to ERR with no writes.
REQ-021 On accepting the low data byte, the FSM SHALL enter WRITE; in WRITE, mem_save SHALL be high for exactly one cycle with mem_in = {hi,lo} and mem_addr = the current address.
REQ-022 After WRITE, the address SHALL increment; when the written-word total equals count, the FSM SHALL go to DONE or CHECK, otherwise to DATA_HI.
REQ-023 When count = 2**ADDR_W, the last write SHALL go to address 2**ADDR_W-1; the address SHALL never wrap within one load.
REQ-024 rx_valid low SHALL stall the FSM in its current state with no timeout.
REQ-025 cpu_halt SHALL be high in every state except DONE.
REQ-026 mem_save SHALL be low in every state other than WRITE; mem_addr and mem_in SHALL hold their value between writes.

Reset
REQ-027 On rst_n low: state = IDLE, rx_ready = 0, mem_save = 0, mem_addr = 0, mem_in = 0, done = 0, error = 0, cpu_halt = 1, counters = 0.
REQ-028 Reset mid-load SHALL abandon the load immediately; partially written memory SHALL be left as is.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined, CHECK SHALL accept one byte after the last word; it SHALL enter DONE if that byte equals the XOR of all data bytes (count bytes excluded), otherwise ERR.
REQ-030 Without LOADER_CHECKSUM_EN, the CHECK state and XOR register SHALL be absent, and completion SHALL go straight to DONE.

Structure
REQ-031 The state enum, ADDR_W/DATA_W defaults and byte width SHALL live in shared package loader_pkg.
REQ-032 The implementation SHALL be a single module with no sub-modules; the XOR accumulator SHALL be inline.

Verification
REQ-033 Reset, then start, then bytes 00 02 12 34 AB CD -> mem_save pulses at addr 0 with 1234 and at addr 1 with ABCD, then done=1 and cpu_halt=0.
REQ-034 Count 00 00 -> done=1 after the second count byte, zero mem_save pulses.
REQ-035 Count 04 01 (1025) -> error=1, cpu_halt=1, no writes; a following start clears error.
REQ-036 rx_valid toggled every other cycle during the REQ-033 stream -> identical writes, no duplicated or lost bytes.
REQ-037 rst_n pulsed low after the first data byte -> all outputs at reset values, no further mem_save.
REQ-038 With LOADER_CHECKSUM_EN: stream 00 01 12 34 26 -> done; stream 00 01 12 34 27 -> error after the single write.
